// File: rtl/bp_stats_if.sv
// Branch-statistics probe bundle between the core (master) and the stats collector (slave).
interface bp_stats_if #(
  parameter int unsigned CNT_W = 32
);
  logic             br_instr_i;
  logic             br_miss_i;
  logic [31:0]      instr_i;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] br_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;
  logic             done_o;
  logic             anomaly_o;
  logic [7:0]       max_streak_o;

  modport master (
    output br_instr_i, br_miss_i, instr_i,
    input  cycle_cnt_o, br_cnt_o, miss_cnt_o, done_o, anomaly_o, max_streak_o
  );

  modport slave (
    input  br_instr_i, br_miss_i, instr_i,
    output cycle_cnt_o, br_cnt_o, miss_cnt_o, done_o, anomaly_o, max_streak_o
  );
endinterface

// File: rtl/bp_stats_collector.sv
// Branch-predictor statistics collector: counts cycles/branches/misses until halt + drain, then freezes.
// Optional longest-misprediction-streak tracking is enabled by defining BP_STATS_STREAK_EN.
module bp_stats_collector #(
  parameter int unsigned CNT_W        = 32,
  parameter logic [31:0] HALT_INSN    = 32'h0000_006F,
  parameter int unsigned HALT_REPEAT  = 4,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  bp_stats_if.slave  probe
);

  localparam logic [3:0] HALT_MAX   = 4'(HALT_REPEAT);
  localparam logic [3:0] HALT_LAST  = 4'(HALT_REPEAT - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam bit         DRAIN_ZERO = (DRAIN_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [3:0]       halt_cnt_r;
  logic [3:0]       drain_cnt_r;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] br_cnt_r;
  logic [CNT_W-1:0] miss_cnt_r;
  logic             done_r;
  logic             anomaly_r;
  logic             count_en_s;
  logic             halt_match_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // With a zero-length drain the single DRAIN edge is not a counted cycle.
  always_comb begin
    count_en_s   = (state_r == ST_RUN) || ((state_r == ST_DRAIN) && !DRAIN_ZERO);
    halt_match_s = (probe.instr_i == HALT_INSN);
  end

  // Run/drain/done FSM together with the saturating statistics counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_RUN;
      halt_cnt_r  <= 4'd0;
      drain_cnt_r <= 4'd0;
      cycle_cnt_r <= '0;
      br_cnt_r    <= '0;
      miss_cnt_r  <= '0;
      done_r      <= 1'b0;
      anomaly_r   <= 1'b0;
    end else if (clear_i) begin
      state_r     <= ST_RUN;
      halt_cnt_r  <= 4'd0;
      drain_cnt_r <= 4'd0;
      cycle_cnt_r <= '0;
      br_cnt_r    <= '0;
      miss_cnt_r  <= '0;
      done_r      <= 1'b0;
      anomaly_r   <= 1'b0;
    end else begin
      if (count_en_s) begin
        cycle_cnt_r <= sat_inc(cycle_cnt_r);
        if (probe.br_instr_i) begin
          br_cnt_r <= sat_inc(br_cnt_r);
        end
        if (probe.br_miss_i) begin
          miss_cnt_r <= sat_inc(miss_cnt_r);
        end
      end
      if (probe.br_miss_i && !probe.br_instr_i) begin
        anomaly_r <= 1'b1;
      end
      case (state_r)
        ST_RUN: begin
          if (halt_match_s) begin
            if (halt_cnt_r != HALT_MAX) begin
              halt_cnt_r <= halt_cnt_r + 4'd1;
            end
            if (halt_cnt_r == HALT_LAST) begin
              state_r     <= ST_DRAIN;
              drain_cnt_r <= 4'd0;
            end
          end else begin
            halt_cnt_r <= 4'd0;
          end
        end
        ST_DRAIN: begin
          if (DRAIN_ZERO || (drain_cnt_r == DRAIN_LAST)) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r + 4'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= ST_RUN;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign probe.cycle_cnt_o = cycle_cnt_r;
  assign probe.br_cnt_o    = br_cnt_r;
  assign probe.miss_cnt_o  = miss_cnt_r;
  assign probe.done_o      = done_r;
  assign probe.anomaly_o   = anomaly_r;

`ifdef BP_STATS_STREAK_EN
  logic [7:0] cur_streak_r;
  logic [7:0] max_streak_r;
  logic [7:0] streak_inc_s;

  // Candidate streak length if this cycle extends the current run of misses.
  always_comb begin
    streak_inc_s = cur_streak_r + 8'd1;
  end

  // Current and longest run of consecutive mispredicted branches; non-branch cycles hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_streak_r <= 8'd0;
      max_streak_r <= 8'd0;
    end else if (clear_i) begin
      cur_streak_r <= 8'd0;
      max_streak_r <= 8'd0;
    end else if (count_en_s && probe.br_instr_i) begin
      if (probe.br_miss_i) begin
        if (cur_streak_r != 8'hFF) begin
          cur_streak_r <= streak_inc_s;
          if (streak_inc_s > max_streak_r) begin
            max_streak_r <= streak_inc_s;
          end
        end
      end else begin
        cur_streak_r <= 8'd0;
      end
    end
  end

  assign probe.max_streak_o = max_streak_r;
`else
  assign probe.max_streak_o = 8'd0;
`endif

endmodule
